// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared write-back constants, state encoding and load-code helper
package writeback_unit_pkg;

  localparam logic [3:0] WB_ALU   = 4'd0;
  localparam logic [3:0] WB_MEMB  = 4'd1;
  localparam logic [3:0] WB_MEMBU = 4'd2;
  localparam logic [3:0] WB_MEMH  = 4'd3;
  localparam logic [3:0] WB_MEMHU = 4'd4;
  localparam logic [3:0] WB_MEMW  = 4'd5;
  localparam logic [3:0] WB_PC    = 4'd6;
  localparam logic [3:0] WB_CSR   = 4'd7;
  localparam logic [3:0] WB_MEMWU = 4'd8;
  localparam logic [3:0] WB_MEMD  = 4'd9;

  localparam logic REN_S = 1'b1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // WU and D only exist on a 64-bit datapath; elsewhere they fall back to ALU.
  function automatic logic is_mem_sel(input logic [3:0] sel, input logic wide);
    return (sel >= WB_MEMB && sel <= WB_MEMW) ||
           (wide && (sel == WB_MEMWU || sel == WB_MEMD));
  endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - load lane select, sign/zero extension and misalignment detect
module load_align
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OW = $clog2(XLEN / 8)
) (
  input  logic [3:0]      wb_sel,
  input  logic [OW-1:0]   off,
  input  logic [XLEN-1:0] rdata,
  output logic            is_load,
  output logic            misaligned,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;
  logic [3:0]      size;

  always_comb begin
    lane    = rdata >> {off, 3'b000};
    is_load = is_mem_sel(wb_sel, XLEN == 64);
    data    = lane;
    size    = 4'd1;
    case (wb_sel)
      WB_MEMB:  begin size = 4'd1; data = XLEN'($signed(lane[7:0]));  end
      WB_MEMBU: begin size = 4'd1; data = XLEN'(lane[7:0]);           end
      WB_MEMH:  begin size = 4'd2; data = XLEN'($signed(lane[15:0])); end
      WB_MEMHU: begin size = 4'd2; data = XLEN'(lane[15:0]);          end
      WB_MEMW:  begin size = 4'd4; data = XLEN'($signed(lane[31:0])); end
      WB_MEMWU: begin size = 4'd4; data = XLEN'(lane[31:0]);          end
      WB_MEMD:  begin size = 4'd8; data = lane;                       end
      default:  begin size = 4'd1; data = lane;                       end
    endcase
    misaligned = is_load && ((4'(off) & (size - 4'd1)) != 4'd0);
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - write-back stage: register file, load extension, next-PC and retire counter
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] SP_INIT  = XLEN'(1000),
  localparam int             RW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_br_target,
  input  logic [XLEN-1:0] in_csr_rdata,
  input  logic [3:0]      in_wb_sel,
  input  logic [RW-1:0]   in_wb_addr,
  input  logic            in_rf_wen,
  input  logic            in_jmp_flg,
  input  logic            in_br_flg,
  input  logic            in_is_ecall,
  input  logic            in_is_mret,
  input  logic [XLEN-1:0] trap_vector,
  input  logic [XLEN-1:0] mepc,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [RW-1:0]   rs1_addr,
  input  logic [RW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            next_pc_valid,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned,
  output logic [63:0]     retire_count
);

  localparam int OW = $clog2(XLEN / 8);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] csr_rdata;
    logic [3:0]      sel;
    logic [RW-1:0]   addr;
    logic            rf_wen;
    logic            jmp;
    logic            br;
    logic            ecall;
    logic            mret;
  } instr_t;

  wb_state_e       state;
  instr_t          live, held, cur;
  logic [XLEN-1:0] regs [NREG];
  logic            ld, ld_mis, accept, retire, wen;
  logic [XLEN-1:0] ld_data, pc_plus4, wdata, npc_d;

  always_comb begin
    live = '{pc: in_pc, alu: in_alu_out, br_target: in_br_target, csr_rdata: in_csr_rdata,
             sel: in_wb_sel, addr: in_wb_addr, rf_wen: in_rf_wen, jmp: in_jmp_flg,
             br: in_br_flg, ecall: in_is_ecall, mret: in_is_mret};
    cur  = (state == ST_WAIT_MEM) ? held : live;
  end

  load_align #(.XLEN(XLEN)) u_align (
    .wb_sel     (cur.sel),
    .off        (cur.alu[OW-1:0]),
    .rdata      (mem_rdata),
    .is_load    (ld),
    .misaligned (ld_mis),
    .data       (ld_data)
  );

  assign in_ready = (state == ST_IDLE);
  assign accept   = (state == ST_IDLE) && in_valid;
  assign retire   = (accept && (!ld || mem_rvalid)) || (state == ST_WAIT_MEM && mem_rvalid);
  assign pc_plus4 = cur.pc + XLEN'(4);
  assign wen      = retire && (cur.rf_wen == REN_S) && (cur.addr != '0) && !ld_mis;

  always_comb begin
    if (ld)                   wdata = ld_data;
    else if (cur.sel == WB_PC)  wdata = pc_plus4;
    else if (cur.sel == WB_CSR) wdata = cur.csr_rdata;
    else                        wdata = cur.alu;

    // A misaligned load traps regardless of any branch/jump flags.
    if (ld_mis)         npc_d = trap_vector;
    else if (cur.br)    npc_d = cur.br_target;
    else if (cur.jmp)   npc_d = {cur.alu[XLEN-1:1], 1'b0};
    else if (cur.ecall) npc_d = trap_vector;
    else if (cur.mret)  npc_d = mepc;
    else                npc_d = pc_plus4;
  end

  function automatic logic [XLEN-1:0] read_port(input logic [RW-1:0] a);
    if (a == '0)              return '0;
    if (wen && cur.addr == a) return wdata;
    return regs[a];
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      held          <= '0;
      next_pc_valid <= 1'b0;
      next_pc       <= RESET_PC;
      misaligned    <= 1'b0;
      retire_count  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= (i == 2) ? SP_INIT : '0;
    end else begin
      next_pc_valid <= retire;
      misaligned    <= retire && ld_mis;
      retire_count  <= retire_count + 64'(retire);
      if (retire) next_pc <= npc_d;
      if (wen) regs[cur.addr] <= wdata;
      case (state)
        ST_IDLE: if (accept && ld && !mem_rvalid) begin
          state <= ST_WAIT_MEM;
          held  <= live;
        end
        ST_WAIT_MEM: if (mem_rvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised write-back stage for the in-order RISC-V core: retires one instruction per accepted handshake. On retire it writes the integer register file, extracts and extends load data by byte lane, and publishes the next PC. It adds three things the core's write-back needs: a wait state for late load data, a two-read-port register file with same-cycle write bypass, and a 64-bit retired-instruction counter. It sits after the memory stage and feeds fetch (`next_pc`) and decode (`rs*_data`).

## Interface
- `XLEN`, default 32. Datapath width; legal values are 32 and 64.
- `NREG`, default 32. Number of integer registers; a power of two, 16 or 32. `RW = $clog2(NREG)`.
- `RESET_PC`, default 0. Reset value of `next_pc`.
- `SP_INIT`, default 1000. Reset value of x2.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1 / `in_ready` out 1: instruction handshake.
- `in_pc`, `in_alu_out`, `in_br_target`, `in_csr_rdata` in XLEN each.
- `in_wb_sel` in 4: write-back source code.
- `in_wb_addr` in RW: destination register.
- `in_rf_wen`, `in_jmp_flg`, `in_br_flg`, `in_is_ecall`, `in_is_mret` in 1 each.
- `trap_vector`, `mepc` in XLEN: live CSR values.
- `mem_rvalid` in 1 / `mem_rdata` in XLEN: naturally aligned load word.
- `rs1_addr`, `rs2_addr` in RW / `rs1_data`, `rs2_data` out XLEN: register read ports.
- `next_pc_valid` out 1 / `next_pc` out XLEN: redirect to fetch.
- `misaligned` out 1: load-misalignment pulse.
- `retire_count` out 64: retired-instruction counter.

## Operation
- States: IDLE and WAIT_MEM. `in_ready = (state == IDLE)`.
- A load is any `in_wb_sel` in the MEM* group.
- Accept in IDLE with a load and `mem_rvalid = 0`: latch all `in_*` fields, move to WAIT_MEM. While in WAIT_MEM, the latched fields are used and new inputs are ignored.
- Retire happens on either of these:
  - accept of a non-load;
  - accept of a load with `mem_rvalid = 1`;
  - `mem_rvalid = 1` in WAIT_MEM, after which the state returns to IDLE.
- Load lane: `off = alu_out[$clog2(XLEN/8)-1:0]`.
  - B/BU take the byte at `off`.
  - H/HU take the halfword at `off`.
  - W/WU take the word at `off`. WU and D are legal only when XLEN = 64.
  - Signed codes sign-extend to XLEN; U codes zero-extend.
- Misaligned load: `off` not a multiple of the access size.
  - No register write; `next_pc = trap_vector`; `misaligned` pulses.
  - The instruction still counts as retired.
- Write data by source: `in_wb_sel` PC gives `pc + 4` (modulo 2^XLEN), CSR gives `csr_rdata`, ALU or any unused code gives `alu_out`.
- Register write occurs on retire when `rf_wen = 1` and `wb_addr != 0`. x0 always reads 0.
- Next-PC priority: `br_flg` → `br_target`; `jmp_flg` → `alu_out` with bit 0 cleared; `is_ecall` → `trap_vector`; `is_mret` → `mepc`; otherwise `pc + 4`.
- Read bypass: if a retiring write targets a read port's address in the same cycle, that port returns the write data. Reads are otherwise combinational from the array.
- `retire_count` increments by 1 per retire and wraps at 2^64.

## Timing
- Reset (synchronous) sets:
  - state IDLE;
  - `next_pc_valid = 0`, `next_pc = RESET_PC`, `misaligned = 0`, `retire_count = 0`;
  - x2 to `SP_INIT`, all other registers to 0.
- `reset` in WAIT_MEM drops the latched instruction: no write, no count.
- Register write and `retire_count` update take effect on the retire edge.
- `next_pc`, `next_pc_valid` and `misaligned` are registered. They are valid the cycle after retire and high for exactly 1 cycle; `next_pc` holds its value otherwise.
- Latency is 0 extra cycles when load data arrives on accept. Otherwise it is one cycle per WAIT_MEM cycle.
- `mem_rvalid` in IDLE with no load accepted is ignored.
- Back-to-back retires are allowed every cycle.

## Structure
- The shared core constants include holds:
  - WB codes: ALU=0, MEMB=1, MEMBU=2, MEMH=3, MEMHU=4, MEMW=5, PC=6, CSR=7, MEMWU=8, MEMD=9;
  - `REN_S`;
  - the state encoding.
- One sub-module, `load_align`: combinational lane select, extension and misalignment detect, parametrised by XLEN.

## Test plan
- Reset, then read all registers → x2 = 1000, others 0. `retire_count = 0`, `next_pc = 0`, `next_pc_valid = 0`.
- ALU write: x5 ← 0x1234, with a same-cycle read of x5 → bypass returns 0x1234. A write to x0 → x0 still reads 0.
- LB, `alu_out = 0x103`, `mem_rdata = 0x80FF_0000`, `mem_rvalid` 3 cycles late → `in_ready` low for 3 cycles, rd = 0xFFFF_FF80. LBU of the same data → 0x0000_0080.
- LH at `off = 3` → no write; `next_pc = trap_vector`; `misaligned` one pulse; count +1.
- Priority: `br_flg` and `is_ecall` together → `br_target`. JAL with `alu_out = 0x201` → `next_pc = 0x200` and rd = pc + 4.
- XLEN = 64, NREG = 16: LW of 0x8000_0000 → sign-extended to 64 bits, LWU → zero-extended. Also run 70 back-to-back retires, then assert `reset` during WAIT_MEM → count cleared and no write occurs.
